// File: rtl/dispatcher_pkg.sv
// Shared definitions for the bus dispatcher: FSM encoding, bridge message codes
// and CPU activity flags.
package dispatcher_pkg;

   localparam logic [2:0] S_RST     = 3'd0;
   localparam logic [2:0] S_ENUM    = 3'd1;
   localparam logic [2:0] S_IDLE    = 3'd2;
   localparam logic [2:0] S_GRANT   = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_RELEASE = 3'd5;

   localparam logic [7:0] CPU_R_START = 8'h01;
   localparam logic [7:0] CPU_R_END   = 8'h02;

   localparam logic CPU_ACTIVE    = 1'b1;
   localparam logic CPU_NONACTIVE = 1'b0;

   // Round-robin successor; n is never zero when a grant has been issued.
   function automatic logic [7:0] rr_next(input logic [7:0] p, input logic [7:0] n);
      logic [8:0] s;
      s = {1'b0, p} + 9'd1;
      return (s >= {1'b0, n}) ? 8'd0 : s[7:0];
   endfunction

endpackage

// File: rtl/bus_dispatcher_if.sv
// Dispatcher <-> CPU bridge bus. master = dispatcher side, slave = bridge side.
interface bus_dispatcher_if;
   import dispatcher_pkg::*;

   logic        ext_rst_b;
   logic        ext_rst_e;
   logic        ext_next_cpu_q;
   logic        ext_next_cpu_e;
   logic [31:0] ext_cpu_index_o;
   logic [7:0]  ext_cpu_msg;
   logic        ext_dispatcher_q;
   logic        ext_bus_busy;

   modport master (
      output ext_rst_b, ext_next_cpu_q, ext_cpu_index_o,
      input  ext_rst_e, ext_next_cpu_e, ext_cpu_msg, ext_dispatcher_q, ext_bus_busy
   );

   modport slave (
      input  ext_rst_b, ext_next_cpu_q, ext_cpu_index_o,
      output ext_rst_e, ext_next_cpu_e, ext_cpu_msg, ext_dispatcher_q, ext_bus_busy
   );

endinterface

// File: rtl/dispatcher_timer.sv
// Loadable down-counter. expire flags the terminal count, i.e. the cycle on which
// one more decrement runs the interval out.
module dispatcher_timer
   import dispatcher_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/bus_dispatcher.sv
// Bus dispatcher: enumerates CPU bridges after reset, then grants the bus round-robin.
// Optional grant/timeout statistics when DISPATCHER_STATS_EN is defined.
module bus_dispatcher
   import dispatcher_pkg::*;
#(
   parameter int MAX_CPUS = 4,
   parameter int TIMEOUT  = 15
) (
   input  logic             clk,
   input  logic             rst,
   bus_dispatcher_if.master bus,
   output logic [7:0]       cpu_count,
   output logic [7:0]       active_count,
   output logic             disp_err
`ifdef DISPATCHER_STATS_EN
   ,
   output logic [15:0]      grant_cnt,
   output logic [7:0]       tout_cnt
`endif
);

   localparam logic [7:0] MAXC = 8'(MAX_CPUS);
   localparam logic [7:0] TOUT = 8'(TIMEOUT);

   logic [2:0] state_q, state_d;
   logic       rst_b_q, rst_b_d;
   logic [7:0] cpu_count_q, cpu_count_d;
   logic [7:0] active_count_q, active_count_d;
   logic [7:0] ptr_q, ptr_d;
   logic       disp_err_q, disp_err_d;
   logic       tmr_load, tmr_dec, tmr_exp;
`ifdef DISPATCHER_STATS_EN
   logic [15:0] grant_cnt_q, grant_cnt_d;
   logic [7:0]  tout_cnt_q, tout_cnt_d;
`endif

   dispatcher_timer #(.W(8)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (TOUT),
      .dec      (tmr_dec),
      .expire   (tmr_exp)
   );

   always_comb begin
      state_d        = state_q;
      rst_b_d        = 1'b0;
      cpu_count_d    = cpu_count_q;
      active_count_d = active_count_q;
      ptr_d          = ptr_q;
      disp_err_d     = disp_err_q;
      tmr_load       = 1'b0;
      tmr_dec        = 1'b0;
`ifdef DISPATCHER_STATS_EN
      grant_cnt_d    = grant_cnt_q;
      tout_cnt_d     = tout_cnt_q;
`endif
      case (state_q)
         // Two cycles here so the broadcast is one full registered cycle.
         S_RST: begin
            tmr_load = 1'b1;
            rst_b_d  = !rst_b_q;
            if (rst_b_q) state_d = S_ENUM;
         end
         S_ENUM: begin
            if (bus.ext_rst_e) begin
               cpu_count_d = cpu_count_q + 8'd1;
               tmr_load    = 1'b1;
            end else begin
               tmr_dec = 1'b1;
            end
            if ((cpu_count_d == MAXC) || (!bus.ext_rst_e && tmr_exp))
               state_d = S_IDLE;
         end
         S_IDLE: begin
            if (bus.ext_dispatcher_q && !bus.ext_bus_busy) begin
               if (cpu_count_q == 8'd0) disp_err_d = 1'b1;
               else                     state_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            tmr_load = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (bus.ext_next_cpu_e) begin
               if ((bus.ext_cpu_msg == CPU_R_START) && (active_count_q < cpu_count_q))
                  active_count_d = active_count_q + 8'd1;
               else if ((bus.ext_cpu_msg == CPU_R_END) && (active_count_q != 8'd0))
                  active_count_d = active_count_q - 8'd1;
`ifdef DISPATCHER_STATS_EN
               grant_cnt_d = grant_cnt_q + 16'd1;
`endif
               state_d = S_RELEASE;
            end else begin
               tmr_dec = 1'b1;
               if (tmr_exp) begin
                  disp_err_d = 1'b1;
`ifdef DISPATCHER_STATS_EN
                  tout_cnt_d = tout_cnt_q + 8'd1;
`endif
                  state_d = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            if (!bus.ext_next_cpu_e) begin
               ptr_d   = rr_next(ptr_q, cpu_count_q);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_RST;
         rst_b_q        <= 1'b0;
         cpu_count_q    <= 8'd0;
         active_count_q <= 8'd0;
         ptr_q          <= 8'd0;
         disp_err_q     <= 1'b0;
`ifdef DISPATCHER_STATS_EN
         grant_cnt_q    <= 16'd0;
         tout_cnt_q     <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         rst_b_q        <= rst_b_d;
         cpu_count_q    <= cpu_count_d;
         active_count_q <= active_count_d;
         ptr_q          <= ptr_d;
         disp_err_q     <= disp_err_d;
`ifdef DISPATCHER_STATS_EN
         grant_cnt_q    <= grant_cnt_d;
         tout_cnt_q     <= tout_cnt_d;
`endif
      end
   end

   // Grant output decodes straight from state so async reset drops it at once.
   assign bus.ext_rst_b      = rst_b_q;
   assign bus.ext_next_cpu_q = (state_q == S_GRANT) || (state_q == S_WAIT);
   always_comb begin
      bus.ext_cpu_index_o = {24'd0, ptr_q};
      if (state_q == S_RST)       bus.ext_cpu_index_o = 32'd0;
      else if (state_q == S_ENUM) bus.ext_cpu_index_o = {24'd0, cpu_count_q};
   end

   assign cpu_count    = cpu_count_q;
   assign active_count = active_count_q;
   assign disp_err     = disp_err_q;
`ifdef DISPATCHER_STATS_EN
   assign grant_cnt    = grant_cnt_q;
   assign tout_cnt     = tout_cnt_q;
`endif

endmodule

// File: tb/tb_bus_dispatcher.sv
// Randomized self-checking bench for bus_dispatcher against a behavioural bridge-level model.
module tb_bus_dispatcher;
   import dispatcher_pkg::*;

   localparam int T    = 15;
   localparam int MAXC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] cpu_count, active_count;
   logic disp_err;
`ifdef DISPATCHER_STATS_EN
   logic [15:0] grant_cnt;
   logic [7:0]  tout_cnt;
`endif

   bus_dispatcher_if bif();

   bus_dispatcher #(.MAX_CPUS(MAXC), .TIMEOUT(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bif.master),
      .cpu_count    (cpu_count),
      .active_count (active_count),
      .disp_err     (disp_err)
`ifdef DISPATCHER_STATS_EN
      ,
      .grant_cnt    (grant_cnt),
      .tout_cnt     (tout_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int cnt_m, act_m, ptr_m, gcnt_m, tcnt_m;
   bit err_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bif.ext_rst_e = 0; bif.ext_next_cpu_e = 0; bif.ext_cpu_msg = 0;
      bif.ext_dispatcher_q = 0; bif.ext_bus_busy = 0;
      #1;
      chk("rst_rst_b", {31'd0, bif.ext_rst_b}, 0);
      chk("rst_q", {31'd0, bif.ext_next_cpu_q}, 0);
      chk("rst_idx", bif.ext_cpu_index_o, 0);
      chk("rst_cnt", {24'd0, cpu_count}, 0);
      chk("rst_act", {24'd0, active_count}, 0);
      chk("rst_err", {31'd0, disp_err}, 0);
      cnt_m = 0; act_m = 0; ptr_m = 0; gcnt_m = 0; tcnt_m = 0; err_m = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstb_pulse", {31'd0, bif.ext_rst_b}, 1);
      chk("rstb_idx", bif.ext_cpu_index_o, 0);
   endtask

   // pat[k] = bridge acknowledge during enumeration cycle k (k from 1).
   task automatic enum_run(input logic [63:0] pat);
      int idle = 0;
      for (int k = 1; k < 200; k++) begin
         logic e;
         @(negedge clk);
         if (k == 1) chk("rstb_end", {31'd0, bif.ext_rst_b}, 0);
         chk("enum_idx", bif.ext_cpu_index_o, cnt_m);
         chk("enum_q", {31'd0, bif.ext_next_cpu_q}, 0);
         e = (k < 64) ? pat[k] : 1'b0;
         bif.ext_rst_e = e;
         if (e) begin cnt_m++; idle = 0; end
         else idle++;
         if (cnt_m == MAXC || idle == T) break;
      end
      @(negedge clk);
      bif.ext_rst_e = 0;
      chk("enum_cnt", {24'd0, cpu_count}, cnt_m);
   endtask

   // Called at a negedge with the DUT idle. d = answer cycle in WAIT (1..T), 0 = never.
   task automatic grant(input int busy_pre, input int d, input int hold,
                        input logic [7:0] m, input bit busy_mid);
      bit answered = 0;
      bif.ext_dispatcher_q = 1;
      bif.ext_bus_busy = (busy_pre > 0);
      for (int i = 0; i < busy_pre; i++) begin
         @(negedge clk);
         chk("busy_block_q", {31'd0, bif.ext_next_cpu_q}, 0);
      end
      bif.ext_bus_busy = 0;
      @(negedge clk);
      chk("gnt_q", {31'd0, bif.ext_next_cpu_q}, 1);
      chk("gnt_idx", bif.ext_cpu_index_o, ptr_m);
      bif.ext_next_cpu_e = 0;
      for (int k = 1; k <= T + 1; k++) begin
         @(negedge clk);
         if (d > 0 && k == d + 1) begin
            chk("rel_q", {31'd0, bif.ext_next_cpu_q}, 0);
            if (m == CPU_R_START && act_m < cnt_m) act_m++;
            else if (m == CPU_R_END && act_m > 0) act_m--;
            gcnt_m++;
            answered = 1;
            break;
         end
         if (d == 0 && k == T + 1) begin
            chk("tout_q", {31'd0, bif.ext_next_cpu_q}, 0);
            err_m = 1;
            tcnt_m++;
            break;
         end
         chk("wait_q", {31'd0, bif.ext_next_cpu_q}, 1);
         chk("wait_idx", bif.ext_cpu_index_o, ptr_m);
         bif.ext_bus_busy = busy_mid & $urandom_range(0, 1);
         if (k == d) begin
            bif.ext_next_cpu_e = 1;
            bif.ext_cpu_msg = m;
         end
      end
      bif.ext_dispatcher_q = 0;
      bif.ext_bus_busy = 0;
      if (answered) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rel_hold_q", {31'd0, bif.ext_next_cpu_q}, 0);
            chk("rel_hold_act", {24'd0, active_count}, act_m);
         end
      end
      bif.ext_next_cpu_e = 0;
      bif.ext_cpu_msg = 8'($urandom);
      @(negedge clk);
      ptr_m = (ptr_m + 1) % cnt_m;
      chk("post_act", {24'd0, active_count}, act_m);
      chk("post_err", {31'd0, disp_err}, err_m);
`ifdef DISPATCHER_STATS_EN
      chk("stat_gnt", {16'd0, grant_cnt}, gcnt_m % 65536);
      chk("stat_tout", {24'd0, tout_cnt}, tcnt_m % 256);
`endif
   endtask

   task automatic rand_grant();
      logic [7:0] m;
      int d, sel;
      sel = $urandom_range(0, 2);
      m = (sel == 0) ? CPU_R_START : (sel == 1) ? CPU_R_END : 8'($urandom);
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, T);
      grant($urandom_range(0, 2), d, $urandom_range(0, 3), m, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] pat;
      bif.ext_rst_e = 0; bif.ext_next_cpu_e = 0; bif.ext_cpu_msg = 0;
      bif.ext_dispatcher_q = 0; bif.ext_bus_busy = 0;

      // Sparse enumeration: acks at cycles 2,4,6, exit after the idle window.
      do_reset();
      enum_run(64'h54);

      // Round-robin over three CPUs with a neutral message.
      for (int i = 0; i < 4; i++) grant(0, 2, 0, 8'h00, 0);
      // active_count tracking and floor at zero
      grant(0, 2, 0, CPU_R_START, 0);
      grant(0, 2, 0, CPU_R_START, 0);
      grant(0, 2, 0, CPU_R_END, 0);
      grant(0, 2, 0, CPU_R_END, 0);
      grant(0, 2, 0, CPU_R_END, 0);
      // Unanswered grant, then the next CPU in line
      grant(0, 0, 0, 8'h00, 0);
      grant(0, 1, 0, CPU_R_START, 0);
      // busy blocks the start, busy mid-grant does not abort, answer on last cycle
      grant(3, T, 2, CPU_R_START, 1);

      // Reset while waiting for the bridge
      bif.ext_dispatcher_q = 1;
      @(negedge clk);
      chk("pre_rst_gnt_q", {31'd0, bif.ext_next_cpu_q}, 1);
      bif.ext_dispatcher_q = 0;
      @(negedge clk);
      chk("pre_rst_wait_q", {31'd0, bif.ext_next_cpu_q}, 1);
      #2 rst = 1'b1;
      #1 chk("rst_async_q", {31'd0, bif.ext_next_cpu_q}, 0);
      do_reset();
      // Back-to-back acks fill the table and leave enumeration at once
      enum_run(64'h1E);
      grant(0, 3, 1, CPU_R_START, 0);

      // No CPUs enumerated: a request only raises the error flag
      do_reset();
      enum_run(64'h0);
      bif.ext_dispatcher_q = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("zero_cpu_q", {31'd0, bif.ext_next_cpu_q}, 0);
      end
      bif.ext_dispatcher_q = 0;
      chk("zero_cpu_err", {31'd0, disp_err}, 1);

      // Random enumerations and grant streams
      for (int r = 0; r < 4; r++) begin
         do_reset();
         pat = '0;
         for (int k = 1; k < 64; k++) pat[k] = ($urandom_range(0, 7) == 0);
         enum_run(pat);
         if (cnt_m > 0)
            for (int g = 0; g < 15; g++) rand_grant();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
